// File: rtl/ara_eoc_pkg.sv
// Shared types for the Ara end-of-computation monitor.
// Latency: n/a (types only).
// Backpressure: none.
package ara_eoc_pkg;

  // Monitor life cycle: wait for start, watch the channels, hold results until cleared.
  typedef enum logic [1:0] {
    EocIdle,
    EocRun,
    EocFinish
  } eoc_state_e;

  // Aggregate verdict presented to the bench wrapper.
  typedef struct packed {
    logic done;
    logic fail;
    logic timeout;
  } eoc_status_t;

endpackage

// File: rtl/ara_eoc_channel.sv
// Per-channel first-exit latch: captures the first valid tohost word seen while enabled.
// Latency: exit_i sampled -> vld_o/code_o one cycle later.
// Backpressure: none; later writes to a latched channel are dropped.
//
// Ports:
//   clk_i, rst_i  clock, async active-high reset
//   en_i          sample enable (monitor in RUN)
//   clear_i       synchronous clear of the latch
//   exit_i        tohost word, bit0 = exit valid, [ExitWidth-1:1] = exit code
//   vld_o         exit latched
//   code_o        latched exit code
module ara_eoc_channel #(
  parameter int unsigned ExitWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 clear_i,
  input  logic [ExitWidth-1:0] exit_i,
  output logic                 vld_o,
  output logic [ExitWidth-2:0] code_o
);

  logic                 vld_q, vld_d;
  logic [ExitWidth-2:0] code_q, code_d;

  always_comb begin
    vld_d  = vld_q;
    code_d = code_q;
    if (clear_i) begin
      vld_d  = 1'b0;
      code_d = '0;
    end else if (en_i && !vld_q && exit_i[0]) begin
      // Only the first exit is captured; the code register is frozen afterwards.
      vld_d  = 1'b1;
      code_d = exit_i[ExitWidth-1:1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      code_q <= '0;
    end else begin
      vld_q  <= vld_d;
      code_q <= code_d;
    end
  end

  assign vld_o  = vld_q;
  assign code_o = code_q;

endmodule

// File: rtl/ara_eoc_monitor.sv
// Multi-channel end-of-computation monitor: latches each channel's first exit,
// aggregates pass/fail, counts RUN cycles (saturating) and runs a watchdog.
// Latency: exit_i -> chan_done_o 1 cycle; completing exit -> done_o 1 cycle.
// Backpressure: none; start_i/clear_i are pulses honoured only in IDLE/FINISH.
//
// Ports:
//   clk_i, rst_i   clock, async active-high reset
//   start_i        IDLE -> RUN, counter cleared
//   clear_i        FINISH -> IDLE, all latches cleared
//   exit_i         packed tohost words, channel c at [c*ExitWidth +: ExitWidth]
//   chan_done_o    per-channel exit latched
//   done_o         all channels exited (sticky)
//   fail_o         some latched channel has a nonzero code
//   timeout_o      watchdog expired first
//   fail_chan_o    lowest failing channel index
//   fail_code_o    exit code of fail_chan_o
//   cycles_o       RUN cycles elapsed, saturating
module ara_eoc_monitor
  import ara_eoc_pkg::*;
#(
  parameter int unsigned NrChannels    = 4,
  parameter int unsigned ExitWidth     = 64,
  parameter int unsigned CntWidth      = 32,
  parameter int unsigned TimeoutCycles = 1000000
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          start_i,
  input  logic                                          clear_i,
  input  logic [NrChannels*ExitWidth-1:0]               exit_i,
  output logic [NrChannels-1:0]                         chan_done_o,
  output logic                                          done_o,
  output logic                                          fail_o,
  output logic                                          timeout_o,
  output logic [$clog2(NrChannels > 1 ? NrChannels : 2)-1:0] fail_chan_o,
  output logic [ExitWidth-2:0]                          fail_code_o,
  output logic [CntWidth-1:0]                           cycles_o
);

  localparam int unsigned IdxW   = $clog2(NrChannels > 1 ? NrChannels : 2);
  localparam logic [63:0] WdLast = 64'(TimeoutCycles) - 64'd1;

  eoc_state_e          state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;
  logic                run, clr;
  logic                all_done, wd_hit;
  logic [NrChannels-1:0] chan_vld, exit_vld;
  logic [ExitWidth-2:0]  chan_code [NrChannels];
  eoc_status_t           status;

  for (genvar c = 0; c < NrChannels; c++) begin : g_chan
    ara_eoc_channel #(
      .ExitWidth(ExitWidth)
    ) u_chan (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (run),
      .clear_i(clr),
      .exit_i (exit_i[c*ExitWidth +: ExitWidth]),
      .vld_o  (chan_vld[c]),
      .code_o (chan_code[c])
    );
  end

  always_comb begin
    exit_vld = '0;
    for (int c = 0; c < NrChannels; c++) begin
      exit_vld[c] = exit_i[c*ExitWidth];
    end
  end

  // Bits latching this cycle count towards completion, so done wins a tie with the watchdog.
  assign all_done = &(chan_vld | exit_vld);
  assign wd_hit   = (TimeoutCycles != 0) && (64'(cnt_q) == WdLast);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    run       = 1'b0;
    clr       = 1'b0;
    unique case (state_q)
      EocIdle: begin
        if (start_i) begin
          state_d = EocRun;
          cnt_d   = '0;
        end
      end
      EocRun: begin
        run = 1'b1;
        // The counter stops on the edge that leaves RUN, so cycles_o names the final RUN cycle.
        if (all_done) begin
          state_d = EocFinish;
          done_d  = 1'b1;
        end else if (wd_hit) begin
          state_d   = EocFinish;
          timeout_d = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      EocFinish: begin
        if (clear_i) begin
          state_d   = EocIdle;
          cnt_d     = '0;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          clr       = 1'b1;
        end
      end
      default: state_d = EocIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= EocIdle;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  // Priority encoder: walk from the top so the lowest failing index is the one kept.
  always_comb begin
    status.done    = done_q;
    status.timeout = timeout_q;
    status.fail    = 1'b0;
    fail_chan_o    = '0;
    fail_code_o    = '0;
    for (int c = NrChannels - 1; c >= 0; c--) begin
      if (chan_vld[c] && (chan_code[c] != '0)) begin
        status.fail = 1'b1;
        fail_chan_o = IdxW'(c);
        fail_code_o = chan_code[c];
      end
    end
  end

  assign chan_done_o = chan_vld;
  assign done_o      = status.done;
  assign fail_o      = status.fail;
  assign timeout_o   = status.timeout;
  assign cycles_o    = cnt_q;

endmodule
